uart8_transmitter: RTL and testbench

Serial transmitter for 8N1 UART frames, the transmit-side partner of the 8-bit receiver. It runs on the same 16x-oversampled baud clock. It accepts a byte on a single-cycle start strobe and shifts out one start bit, eight data bits LSB first, and one stop bit. It reports progress with `busy` and `done`. Its `out` line connects directly to the far end's `in` (rx), and the frame timing matches what the receiver samples.

---
 rtl/uart8_pkg.sv | 20 ++
 rtl/uart8_transmitter_if.sv | 39 +++
 rtl/uart8_transmitter.sv | 179 +++++++++++++++++
 tb/tb_uart8_transmitter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart8_pkg.sv
// uart8_pkg
// Shared definitions for the 8-bit UART transmitter and receiver pair.
// Holds the FSM state encoding, the default oversample factor and the
// data width. The receiver's 2-bit/3-bit state values map onto the low
// bits of the same encoding, so both sides decode identically.
package uart8_pkg;

    localparam int DATA_WIDTH         = 8;
    localparam int INDEX_WIDTH        = 3;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START_BIT = 3'd2,
        ST_DATA_BITS = 3'd3,
        ST_STOP_BIT  = 3'd4
    } uartState_e;

endpackage

// File: rtl/uart8_transmitter_if.sv
// uart8_transmitter_if
// Groups the transmitter's control, data and status signals.
//   en     : block enable (low forces the transmitter into RESET)
//   start  : single-cycle transmit request, honoured only in IDLE
//   in     : byte to send, captured when start is accepted
//   out    : serial tx line, idles high
//   busy   : a frame is in progress
//   done   : one-cycle pulse when a frame completes
// master : the side that requests frames (drives en/start/in)
// slave  : the transmitter itself (drives out/busy/done)
interface uart8_transmitter_if;
    import uart8_pkg::*;

    logic                  en;
    logic                  start;
    logic [DATA_WIDTH-1:0] in;
    logic                  out;
    logic                  busy;
    logic                  done;

    modport master (
        output en,
        output start,
        output in,
        input  out,
        input  busy,
        input  done
    );

    modport slave (
        input  en,
        input  start,
        input  in,
        output out,
        output busy,
        output done
    );

endinterface

// File: rtl/uart8_transmitter.sv
// uart8_transmitter
// Serial transmitter for 8N1 UART frames on the 16x oversampled baud clock.
// A byte accepted on a start strobe is sent as one start bit (low), eight
// data bits LSB first, and one stop bit (high). Every output is registered.
//
// Ports:
//   clk  : baud clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : uart8_transmitter_if.slave (en, start, in, out, busy, done)
//
// Parameter:
//   CLKS_PER_BIT : clk cycles per serial bit, legal range 2..256
//
// Build option:
//   UART8_TX_TWO_STOP_EN : when defined, the stop period lasts two bit
//                          times (8N2). Otherwise one stop bit (8N1).
module uart8_transmitter
    import uart8_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_OVERSAMPLE
) (
    input  logic                clk,
    input  logic                rst,
    uart8_transmitter_if.slave  bus
);

    localparam int                   CNT_WIDTH = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(CLKS_PER_BIT - 1);

    uartState_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]   bitCnt_q, bitCnt_d;
    logic [INDEX_WIDTH-1:0] bitIdx_q, bitIdx_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic                   out_q, out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   bitEnd;
    logic [CNT_WIDTH-1:0]   cntNext;
    logic [INDEX_WIDTH-1:0] idxNext;
    logic                   lastStopBit;

    // bitEnd marks the final clock of the current bit period; the counter
    // wraps there explicitly so non-power-of-two periods work too.
    assign bitEnd  = (bitCnt_q == CNT_LAST);
    assign cntNext = bitEnd ? '0 : bitCnt_q + CNT_WIDTH'(1);
    assign idxNext = bitIdx_q + INDEX_WIDTH'(1);

`ifdef UART8_TX_TWO_STOP_EN
    logic stopSecond_q, stopSecond_d;

    // Tracks which of the two stop bits is on the line. It toggles at the end
    // of each stop bit, so it is back to zero when the frame finishes.
    assign stopSecond_d = (!bus.en || state_q != ST_STOP_BIT) ? 1'b0 :
                          (bitEnd ? ~stopSecond_q : stopSecond_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stopSecond_q <= 1'b0;
        end else begin
            stopSecond_q <= stopSecond_d;
        end
    end

    assign lastStopBit = stopSecond_q;
`else
    assign lastStopBit = 1'b1;
`endif

    // State and datapath registers; reset leaves the line idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RESET;
            bitCnt_q <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            out_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-output logic. The outputs are computed one cycle
    // ahead so that the registered line changes exactly on bit boundaries.
    // done defaults low so it can only ever be a single-cycle pulse.
    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        out_d    = out_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (!bus.en) begin
            // Dropping enable abandons any partial frame with the line high.
            state_d  = ST_RESET;
            bitCnt_d = '0;
            bitIdx_d = '0;
            shift_d  = '0;
            out_d    = 1'b1;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    state_d  = ST_IDLE;
                    bitCnt_d = '0;
                    bitIdx_d = '0;
                    shift_d  = '0;
                    out_d    = 1'b1;
                    busy_d   = 1'b0;
                end
                ST_IDLE: begin
                    out_d  = 1'b1;
                    busy_d = 1'b0;
                    if (bus.start) begin
                        shift_d  = bus.in;
                        busy_d   = 1'b1;
                        bitCnt_d = '0;
                        bitIdx_d = '0;
                        out_d    = 1'b0;
                        state_d  = ST_START_BIT;
                    end
                end
                ST_START_BIT: begin
                    out_d    = 1'b0;
                    bitCnt_d = cntNext;
                    if (bitEnd) begin
                        bitIdx_d = '0;
                        out_d    = shift_q[0];
                        state_d  = ST_DATA_BITS;
                    end
                end
                ST_DATA_BITS: begin
                    out_d    = shift_q[bitIdx_q];
                    bitCnt_d = cntNext;
                    if (bitEnd) begin
                        // The index wraps 7 -> 0 as the stop bit begins.
                        bitIdx_d = idxNext;
                        if (bitIdx_q == INDEX_WIDTH'(DATA_WIDTH - 1)) begin
                            out_d   = 1'b1;
                            state_d = ST_STOP_BIT;
                        end else begin
                            out_d = shift_q[idxNext];
                        end
                    end
                end
                ST_STOP_BIT: begin
                    out_d    = 1'b1;
                    bitCnt_d = cntNext;
                    if (bitEnd && lastStopBit) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    // Unused encodings recover to a quiet idle line.
                    state_d = ST_IDLE;
                    out_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_uart8_transmitter.sv
// tb_uart8_transmitter
// Self-checking bench for uart8_transmitter. Each frame is compared cycle by
// cycle against the ideal line waveform derived from the frame layout, and
// is also decoded by a simple mid-bit-sampling receiver model whose result
// must equal the byte that was sent.
// Honours UART8_TX_TWO_STOP_EN to expect the longer stop period.
module tb_uart8_transmitter;
    import uart8_pkg::*;

    localparam int CPB = 16;
`ifdef UART8_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif
    localparam int FRAME = (1 + DATA_WIDTH + NSTOP) * CPB;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    uart8_transmitter_if ifc();

    uart8_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Ideal line level in cycle c (1-based) of a frame carrying byte b.
    function automatic logic lineAt(input logic [DATA_WIDTH-1:0] b, input int c);
        int slot;
        slot = (c - 1) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DATA_WIDTH) return b[slot-1];
        return 1'b1;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic expOut,
                               input logic expBusy, input logic expDone);
        checks++;
        assert (ifc.out === expOut) else begin
            errors++;
            $error("[TB] FAIL %s out: got=%b expected=%b", tag, ifc.out, expOut);
        end
        checks++;
        assert (ifc.busy === expBusy) else begin
            errors++;
            $error("[TB] FAIL %s busy: got=%b expected=%b", tag, ifc.busy, expBusy);
        end
        checks++;
        assert (ifc.done === expDone) else begin
            errors++;
            $error("[TB] FAIL %s done: got=%b expected=%b", tag, ifc.done, expDone);
        end
    endtask

    task automatic checkIdle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            checkOutput(tag, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Sends byte b starting from a cycle where the DUT is idle, checks every
    // frame cycle and ends in the done cycle. Nonzero injectAt pulses start
    // with 0xFF in that cycle; nonzero enDropAt / rstAt abort the frame there.
    task automatic applyStimulus(input logic [DATA_WIDTH-1:0] b, input int injectAt,
                                 input int enDropAt, input int rstAt);
        logic [DATA_WIDTH-1:0] decoded;
        int slot;
        decoded   = '0;
        ifc.in    = b;
        ifc.start = 1'b1;
        nextCycle();
        ifc.start = 1'b0;
        ifc.in    = DATA_WIDTH'($urandom);
        for (int c = 1; c <= FRAME; c++) begin
            checkOutput("frame", lineAt(b, c), 1'b1, 1'b0);
            slot = (c - 1) / CPB;
            if (((c - 1) % CPB) == CPB / 2 && slot >= 1 && slot <= DATA_WIDTH)
                decoded[slot-1] = ifc.out;
            ifc.start = 1'b0;
            if (c == injectAt) begin
                ifc.in    = 8'hFF;
                ifc.start = 1'b1;
            end
            if (c == enDropAt) begin
                ifc.en = 1'b0;
                nextCycle();
                checkOutput("enDrop", 1'b1, 1'b0, 1'b0);
                return;
            end
            if (c == rstAt) begin
                #2 rst = 1'b1;
                #1;
                checkOutput("asyncRst", 1'b1, 1'b0, 1'b0);
                return;
            end
            nextCycle();
        end
        checkOutput("doneCycle", 1'b1, 1'b0, 1'b1);
        checks++;
        assert (decoded === b) else begin
            errors++;
            $error("[TB] FAIL rxDecode: got=%h expected=%h", decoded, b);
        end
    endtask

    initial begin
        rst       = 1'b1;
        ifc.en    = 1'b1;
        ifc.start = 1'b0;
        ifc.in    = '0;

        // Reset state, then one edge to leave RESET.
        #12;
        checkOutput("resetState", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        nextCycle();
        checkOutput("idleAfterReset", 1'b1, 1'b0, 1'b0);

        $display("[TB] frame 0x55");
        applyStimulus(8'h55, 0, 0, 0);
        checkIdle("donePulseOnce", 2);

        $display("[TB] back-to-back 0xA5 then 0x00");
        applyStimulus(8'hA5, 0, 0, 0);
        applyStimulus(8'h00, 0, 0, 0);
        checkIdle("afterBackToBack", 2);

        $display("[TB] start ignored mid-frame");
        applyStimulus(8'h3C, 50, 0, 0);
        checkIdle("noQueuedFrame", 2 * CPB);

        $display("[TB] enable dropped mid-frame");
        applyStimulus(DATA_WIDTH'($urandom), 0, 70, 0);
        checkIdle("enLow", 3);
        ifc.en    = 1'b1;
        ifc.start = 1'b1;
        ifc.in    = 8'h96;
        nextCycle();
        checkOutput("startIgnoredInReset", 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h96, 0, 0, 0);
        checkIdle("afterEnReturn", 1);

        $display("[TB] async reset mid-data-bit");
        applyStimulus(8'h00, 0, 0, 40);
        #2 rst = 1'b0;
        nextCycle();
        checkOutput("idleAfterAsyncRst", 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h5A, 0, 0, 0);
        checkIdle("afterRstFrame", 1);

        $display("[TB] loopback directed and random bytes");
        applyStimulus(8'h00, 0, 0, 0);
        applyStimulus(8'hFF, 0, 0, 0);
        applyStimulus(8'h81, 0, 0, 0);
        for (int i = 0; i < 256; i++)
            applyStimulus(DATA_WIDTH'($urandom), 0, 0, 0);
        checkIdle("finalIdle", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
